tcp_log_mem_arbiter: RTL and testbench

// - Shares one Avalon-style memory port (memA/memB class) between two requesters: the TCP logger write path (client 0) and the replay read path (client 1).
// - Round-robin arbitration of commands; write bursts are locked until their last beat.
// - In-order tag FIFO routes read-response beats back to the issuing client.
// - Sits between tcp_log_replay_top clients and a memory (ram_1rw_byte_mask_out_reg_wrap in sim, DDR in HW).

---
 rtl/tcp_log_mem_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_tcp_log_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_log_mem_arbiter.sv
// tcp_log_mem_arbiter: two-client round-robin arbiter onto one Avalon-style
// memory port. Client 0 = logger write path, client 1 = replay read path.
// Write bursts hold the grant until their last beat. An in-order tag FIFO
// steers read-response beats back to the issuing client.
// Optional build macro TCP_LOG_MEM_ARB_PERF_EN adds per-client grant/stall counters.
`ifndef MEM_ADDR_W
`define MEM_ADDR_W 32
`endif
`ifndef MEM_DATA_W
`define MEM_DATA_W 32
`endif
`ifndef MEM_BURST_CNT_W
`define MEM_BURST_CNT_W 4
`endif

module tcp_log_mem_arbiter #(
  parameter int MEM_ADDR_W      = `MEM_ADDR_W,
  parameter int MEM_DATA_W      = `MEM_DATA_W,
  parameter int MEM_BURST_CNT_W = `MEM_BURST_CNT_W,
  parameter int LOG_OUTSTANDING = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         c0_read_in,
  input  logic                         c0_write_in,
  input  logic [MEM_ADDR_W-1:0]        c0_address_in,
  input  logic [MEM_DATA_W-1:0]        c0_writedata_in,
  input  logic [MEM_BURST_CNT_W-1:0]   c0_burstcount_in,
  input  logic [MEM_DATA_W/8-1:0]      c0_byteenable_in,
  output logic                         c0_ready_out,
  output logic [MEM_DATA_W-1:0]        c0_readdata_out,
  output logic                         c0_readdatavalid_out,
  input  logic                         c1_read_in,
  input  logic                         c1_write_in,
  input  logic [MEM_ADDR_W-1:0]        c1_address_in,
  input  logic [MEM_DATA_W-1:0]        c1_writedata_in,
  input  logic [MEM_BURST_CNT_W-1:0]   c1_burstcount_in,
  input  logic [MEM_DATA_W/8-1:0]      c1_byteenable_in,
  output logic                         c1_ready_out,
  output logic [MEM_DATA_W-1:0]        c1_readdata_out,
  output logic                         c1_readdatavalid_out,
  input  logic                         mem_ready_in,
  output logic                         mem_read_out,
  output logic                         mem_write_out,
  output logic [MEM_ADDR_W-1:0]        mem_address_out,
  output logic [MEM_DATA_W-1:0]        mem_writedata_out,
  output logic [MEM_BURST_CNT_W-1:0]   mem_burstcount_out,
  output logic [MEM_DATA_W/8-1:0]      mem_byteenable_out,
  input  logic [MEM_DATA_W-1:0]        mem_readdata_in,
  input  logic                         mem_readdatavalid_in,
`ifdef TCP_LOG_MEM_ARB_PERF_EN
  output logic [31:0]                  c0_grant_cnt_out,
  output logic [31:0]                  c0_stall_cnt_out,
  output logic [31:0]                  c1_grant_cnt_out,
  output logic [31:0]                  c1_stall_cnt_out,
`endif
  output logic                         err_out
);

  localparam int DEPTH = 1 << LOG_OUTSTANDING;
  localparam int BCW   = MEM_BURST_CNT_W;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0]                 state_q, state_d;
  logic                       rr_ptr_q, rr_ptr_d;   // client favoured on a tie
  logic                       owner_q, owner_d;
  logic [BCW-1:0]             remaining_q, remaining_d;
  logic                       err_q, err_d;
  logic [DEPTH-1:0]           tag_cli_q, tag_cli_d;
  logic [DEPTH-1:0][BCW-1:0]  tag_bc_q, tag_bc_d;
  logic [LOG_OUTSTANDING-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LOG_OUTSTANDING:0]   cnt_q, cnt_d;
  logic [BCW-1:0]             beat_q, beat_d;

  logic                       req0, req1, gnt, g_read, g_write, fwd_read, fwd_write, acc;
  logic                       tag_full, push, pop, rsp_ok, head_cli;
  logic [MEM_ADDR_W-1:0]      g_addr;
  logic [MEM_DATA_W-1:0]      g_wdata;
  logic [BCW-1:0]             g_bc, g_bc_eff, head_bc;
  logic [MEM_DATA_W/8-1:0]    g_be;

  // Grant selection and command mux; zero-latency pass-through of the winner.
  always_comb begin
    req0 = c0_read_in | c0_write_in;
    req1 = c1_read_in | c1_write_in;
    if (state_q == S_LOCK)  gnt = owner_q;
    else if (req0 && req1)  gnt = rr_ptr_q;
    else                    gnt = req1;
    g_read   = gnt ? c1_read_in       : c0_read_in;
    g_write  = gnt ? c1_write_in      : c0_write_in;
    g_addr   = gnt ? c1_address_in    : c0_address_in;
    g_wdata  = gnt ? c1_writedata_in  : c0_writedata_in;
    g_bc     = gnt ? c1_burstcount_in : c0_burstcount_in;
    g_be     = gnt ? c1_byteenable_in : c0_byteenable_in;
    g_bc_eff = (g_bc == '0) ? BCW'(1) : g_bc;
    tag_full = (cnt_q == (LOG_OUTSTANDING+1)'(DEPTH));
    // Write wins if a client raises both; reads never forwarded inside a lock.
    fwd_write = g_write;
    fwd_read  = g_read & ~g_write & ~tag_full & (state_q == S_IDLE);
    acc       = (fwd_write | fwd_read) & mem_ready_in;
  end

  // Output drive; everything forced low while reset is asserted.
  always_comb begin
    c0_ready_out         = ~rst & acc & ~gnt;
    c1_ready_out         = ~rst & acc &  gnt;
    mem_read_out         = ~rst & fwd_read;
    mem_write_out        = ~rst & fwd_write;
    mem_address_out      = rst ? '0 : g_addr;
    mem_writedata_out    = rst ? '0 : g_wdata;
    mem_burstcount_out   = rst ? '0 : g_bc_eff;
    mem_byteenable_out   = rst ? '0 : g_be;
    c0_readdata_out      = rst ? '0 : mem_readdata_in;
    c1_readdata_out      = rst ? '0 : mem_readdata_in;
    c0_readdatavalid_out = ~rst & rsp_ok & ~head_cli;
    c1_readdatavalid_out = ~rst & rsp_ok &  head_cli;
    err_out              = err_q;
  end

  // Next-state: arbitration/lock bookkeeping, tag FIFO and response beat count.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    remaining_d = remaining_q;
    err_d       = err_q;
    tag_cli_d   = tag_cli_q;
    tag_bc_d    = tag_bc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;

    if (acc) begin
      if (state_q == S_IDLE) begin
        rr_ptr_d = ~gnt;
        if (g_bc == '0) err_d = 1'b1;
        if (fwd_write && g_bc_eff != BCW'(1)) begin
          state_d     = S_LOCK;
          owner_d     = gnt;
          remaining_d = g_bc_eff - BCW'(1);
        end
      end else begin
        remaining_d = remaining_q - BCW'(1);
        if (remaining_q == BCW'(1)) state_d = S_IDLE;
      end
    end
    // Owner dropping write mid-burst is flagged; the lock simply waits.
    if (state_q == S_LOCK && !g_write) err_d = 1'b1;

    push     = acc & fwd_read;
    head_cli = tag_cli_q[rd_ptr_q];
    head_bc  = tag_bc_q[rd_ptr_q];
    rsp_ok   = mem_readdatavalid_in & (cnt_q != '0);
    pop      = rsp_ok & (beat_q == head_bc - BCW'(1));
    if (mem_readdatavalid_in && cnt_q == '0) err_d = 1'b1;
    if (rsp_ok) beat_d = pop ? '0 : beat_q + BCW'(1);

    if (push) begin
      tag_cli_d[wr_ptr_q] = gnt;
      tag_bc_d[wr_ptr_q]  = g_bc_eff;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 1'b0;
      owner_q     <= 1'b0;
      remaining_q <= '0;
      err_q       <= 1'b0;
      tag_cli_q   <= '0;
      tag_bc_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      remaining_q <= remaining_d;
      err_q       <= err_d;
      tag_cli_q   <= tag_cli_d;
      tag_bc_q    <= tag_bc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
    end
  end

`ifdef TCP_LOG_MEM_ARB_PERF_EN
  logic [31:0] c0_grant_cnt_q, c0_grant_cnt_d, c1_grant_cnt_q, c1_grant_cnt_d;
  logic [31:0] c0_stall_cnt_q, c0_stall_cnt_d, c1_stall_cnt_q, c1_stall_cnt_d;

  // Wrapping counters: accepted commands (first beats) and stalled request cycles.
  always_comb begin
    c0_grant_cnt_d = c0_grant_cnt_q + {31'd0, acc & (state_q == S_IDLE) & ~gnt};
    c1_grant_cnt_d = c1_grant_cnt_q + {31'd0, acc & (state_q == S_IDLE) &  gnt};
    c0_stall_cnt_d = c0_stall_cnt_q + {31'd0, req0 & ~c0_ready_out};
    c1_stall_cnt_d = c1_stall_cnt_q + {31'd0, req1 & ~c1_ready_out};
    c0_grant_cnt_out = c0_grant_cnt_q;
    c1_grant_cnt_out = c1_grant_cnt_q;
    c0_stall_cnt_out = c0_stall_cnt_q;
    c1_stall_cnt_out = c1_stall_cnt_q;
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      c0_grant_cnt_q <= '0;
      c1_grant_cnt_q <= '0;
      c0_stall_cnt_q <= '0;
      c1_stall_cnt_q <= '0;
    end else begin
      c0_grant_cnt_q <= c0_grant_cnt_d;
      c1_grant_cnt_q <= c1_grant_cnt_d;
      c0_stall_cnt_q <= c0_stall_cnt_d;
      c1_stall_cnt_q <= c1_stall_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_tcp_log_mem_arbiter.sv
// tb_tcp_log_mem_arbiter: directed scenarios plus a randomized run checked
// against a queue-based model of arbitration and in-order response routing.
module tb_tcp_log_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst;
  logic c0_read, c0_write, c1_read, c1_write;
  logic [AW-1:0] c0_addr, c1_addr, mem_addr;
  logic [DW-1:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata, mem_wdata, mem_rdata;
  logic [BW-1:0] c0_bc, c1_bc, mem_bc;
  logic [DW/8-1:0] c0_be, c1_be, mem_be;
  logic c0_ready, c1_ready, c0_rdv, c1_rdv;
  logic mem_ready, mem_read, mem_write, mem_rdv, err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tcp_log_mem_arbiter #(.MEM_ADDR_W(AW), .MEM_DATA_W(DW), .MEM_BURST_CNT_W(BW),
                        .LOG_OUTSTANDING(3)) dut (
    .clk(clk), .rst(rst),
    .c0_read_in(c0_read), .c0_write_in(c0_write), .c0_address_in(c0_addr),
    .c0_writedata_in(c0_wdata), .c0_burstcount_in(c0_bc), .c0_byteenable_in(c0_be),
    .c0_ready_out(c0_ready), .c0_readdata_out(c0_rdata), .c0_readdatavalid_out(c0_rdv),
    .c1_read_in(c1_read), .c1_write_in(c1_write), .c1_address_in(c1_addr),
    .c1_writedata_in(c1_wdata), .c1_burstcount_in(c1_bc), .c1_byteenable_in(c1_be),
    .c1_ready_out(c1_ready), .c1_readdata_out(c1_rdata), .c1_readdatavalid_out(c1_rdv),
    .mem_ready_in(mem_ready), .mem_read_out(mem_read), .mem_write_out(mem_write),
    .mem_address_out(mem_addr), .mem_writedata_out(mem_wdata),
    .mem_burstcount_out(mem_bc), .mem_byteenable_out(mem_be),
    .mem_readdata_in(mem_rdata), .mem_readdatavalid_in(mem_rdv),
    .err_out(err));

  task automatic clr_inputs();
    c0_read = 0; c0_write = 0; c0_addr = '0; c0_wdata = '0; c0_bc = 4'd1; c0_be = '1;
    c1_read = 0; c1_write = 0; c1_addr = '0; c1_wdata = '0; c1_bc = 4'd1; c1_be = '1;
    mem_ready = 1; mem_rdv = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; clr_inputs();
    @(negedge clk); @(negedge clk); rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1;
    c0_read = 1; c1_write = 1; c1_bc = 4'd3; c0_addr = $urandom; c1_wdata = $urandom;
    mem_ready = 1; mem_rdv = 1; mem_rdata = $urandom;
    #1;
    n_cmp++; if ({c0_ready, c1_ready, mem_read, mem_write} !== 4'b0) begin
      n_err++; $display("FAIL rst_cmd got %b want 0000", {c0_ready, c1_ready, mem_read, mem_write}); end
    n_cmp++; if ({c0_rdv, c1_rdv} !== 2'b0 || mem_addr !== '0 || c0_rdata !== '0) begin
      n_err++; $display("FAIL rst_data rdv=%b addr=%h rdata=%h want zeros", {c0_rdv, c1_rdv}, mem_addr, c0_rdata); end
    @(negedge clk); clr_inputs(); @(negedge clk); rst = 0; #1;
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", err); end
  endtask

  task automatic test_write_lock();
    logic [DW-1:0] d;
    do_reset();
    c0_write = 1; c0_bc = 4'd4; c0_addr = 32'h10; c1_read = 1; c1_addr = $urandom;
    for (int i = 0; i < 4; i++) begin
      d = $urandom; c0_wdata = d; #1;
      n_cmp++; if ({c0_ready, c1_ready, mem_write, mem_read} !== 4'b1010) begin
        n_err++; $display("FAIL wl_ready beat %0d got c0/c1/w/r=%b want 1010", i, {c0_ready, c1_ready, mem_write, mem_read}); end
      n_cmp++; if (mem_wdata !== d) begin n_err++; $display("FAIL wl_wdata beat %0d got %h want %h", i, mem_wdata, d); end
      if (i == 0) begin
        n_cmp++; if (mem_addr !== 32'h10 || mem_bc !== 4'd4) begin
          n_err++; $display("FAIL wl_first got addr=%h bc=%0d want 10/4", mem_addr, mem_bc); end
      end
      @(negedge clk);
    end
    c0_write = 0; #1;
    n_cmp++; if ({c1_ready, mem_read, c0_ready} !== 3'b110) begin
      n_err++; $display("FAIL wl_after got c1/r/c0=%b want 110", {c1_ready, mem_read, c0_ready}); end
    @(negedge clk); c1_read = 0; mem_rdv = 1; d = $urandom; mem_rdata = d; #1;
    n_cmp++; if ({c1_rdv, c0_rdv} !== 2'b10 || c1_rdata !== d) begin
      n_err++; $display("FAIL wl_rsp got rdv1/0=%b data=%h want 10/%h", {c1_rdv, c0_rdv}, c1_rdata, d); end
    @(negedge clk); mem_rdv = 0; #1;
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL wl_err got %b want 0", err); end
  endtask

  task automatic test_alternate();
    int exp_q[$];
    int e;
    logic [DW-1:0] d;
    do_reset();
    c0_read = 1; c1_read = 1;
    e = 0;
    for (int i = 0; i < 8; i++) begin
      c0_addr = $urandom; c1_addr = $urandom; #1;
      n_cmp++; if (c0_ready !== (e == 0) || c1_ready !== (e == 1)) begin
        n_err++; $display("FAIL alt_grant cyc %0d got c0/c1=%b%b want client %0d", i, c0_ready, c1_ready, e); end
      exp_q.push_back(e); e = 1 - e;
      @(negedge clk);
    end
    c0_read = 0; c1_read = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); d = $urandom; mem_rdv = 1; mem_rdata = d; #1;
      n_cmp++; if (c0_rdv !== (e == 0) || c1_rdv !== (e == 1) || c0_rdata !== d) begin
        n_err++; $display("FAIL alt_rsp got rdv0/1=%b%b data=%h want client %0d %h", c0_rdv, c1_rdv, c0_rdata, e, d); end
      @(negedge clk);
    end
    mem_rdv = 0;
  endtask

  task automatic test_burst_steer();
    int exp [5] = '{1, 1, 1, 0, 0};
    do_reset();
    c1_read = 1; c1_bc = 4'd3; #1;
    n_cmp++; if (c1_ready !== 1'b1 || mem_bc !== 4'd3) begin
      n_err++; $display("FAIL bs_c1 got ready=%b bc=%0d want 1/3", c1_ready, mem_bc); end
    @(negedge clk); c1_read = 0; c0_read = 1; c0_bc = 4'd2; #1;
    n_cmp++; if (c0_ready !== 1'b1) begin n_err++; $display("FAIL bs_c0 got ready=%b want 1", c0_ready); end
    @(negedge clk); c0_read = 0;
    for (int i = 0; i < 5; i++) begin
      mem_rdv = 1; mem_rdata = $urandom; #1;
      n_cmp++; if (c0_rdv !== (exp[i] == 0) || c1_rdv !== (exp[i] == 1)) begin
        n_err++; $display("FAIL bs_steer beat %0d got rdv0/1=%b%b want client %0d", i, c0_rdv, c1_rdv, exp[i]); end
      @(negedge clk);
    end
    mem_rdv = 0; #1;
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL bs_err got %b want 0", err); end
  endtask

  task automatic test_full();
    do_reset();
    c0_read = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if (c0_ready !== 1'b1) begin n_err++; $display("FAIL full_fill %0d got %b want 1", i, c0_ready); end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (c0_ready !== 1'b0 || mem_read !== 1'b0) begin
        n_err++; $display("FAIL full_block %0d got ready=%b read=%b want 0/0", i, c0_ready, mem_read); end
      @(negedge clk);
    end
    mem_rdv = 1; mem_rdata = $urandom; #1;
    n_cmp++; if (c0_ready !== 1'b0 || c0_rdv !== 1'b1) begin
      n_err++; $display("FAIL full_popcyc got ready=%b rdv=%b want 0/1", c0_ready, c0_rdv); end
    @(negedge clk); mem_rdv = 0; #1;
    n_cmp++; if (c0_ready !== 1'b1) begin n_err++; $display("FAIL full_after_pop got %b want 1", c0_ready); end
    @(negedge clk); c0_read = 0;
    for (int i = 0; i < 8; i++) begin
      mem_rdv = 1; #1;
      n_cmp++; if (c0_rdv !== 1'b1) begin n_err++; $display("FAIL full_drain %0d got %b want 1", i, c0_rdv); end
      @(negedge clk);
    end
    mem_rdv = 0; #1;
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL full_err got %b want 0", err); end
  endtask

  task automatic test_stall();
    do_reset();
    c0_read = 1; c1_read = 1; #1;   // tie -> client 0 first, pointer moves to 1
    n_cmp++; if (c0_ready !== 1'b1) begin n_err++; $display("FAIL st_first got %b want 1", c0_ready); end
    @(negedge clk); mem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if ({c0_ready, c1_ready} !== 2'b00) begin
        n_err++; $display("FAIL st_hold %0d got %b%b want 00", i, c0_ready, c1_ready); end
      @(negedge clk);
    end
    mem_ready = 1; #1;
    n_cmp++; if ({c0_ready, c1_ready} !== 2'b01) begin
      n_err++; $display("FAIL st_resume got c0/c1=%b%b want 01", c0_ready, c1_ready); end
    @(negedge clk); c0_read = 0; c1_read = 0;
    for (int i = 0; i < 2; i++) begin
      mem_rdv = 1; #1;
      n_cmp++; if (c0_rdv !== (i == 0) || c1_rdv !== (i == 1)) begin
        n_err++; $display("FAIL st_rsp %0d got rdv0/1=%b%b", i, c0_rdv, c1_rdv); end
      @(negedge clk);
    end
    mem_rdv = 0;
  endtask

  task automatic test_err();
    do_reset();
    mem_rdv = 1; mem_rdata = $urandom; #1;
    n_cmp++; if ({c0_rdv, c1_rdv} !== 2'b00) begin
      n_err++; $display("FAIL err_drop got %b%b want 00", c0_rdv, c1_rdv); end
    @(negedge clk); mem_rdv = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky %0d got %b want 1", i, err); end
      @(negedge clk);
    end
    do_reset(); #1;
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL err_clr got %b want 0", err); end
    @(negedge clk); c0_write = 1; c0_bc = 4'd0; #1;
    n_cmp++; if (c0_ready !== 1'b1 || mem_bc !== 4'd1) begin
      n_err++; $display("FAIL bc0_fwd got ready=%b bc=%0d want 1/1", c0_ready, mem_bc); end
    @(negedge clk); c0_write = 0; c1_write = 1; c1_bc = 4'd1; #1;
    n_cmp++; if (err !== 1'b1 || c1_ready !== 1'b1) begin
      n_err++; $display("FAIL bc0_err got err=%b c1_ready=%b want 1/1 (no lock)", err, c1_ready); end
    @(negedge clk); c1_write = 0;
  endtask

  task automatic test_reset_in_lock();
    do_reset();
    c0_write = 1; c0_bc = 4'd4;
    @(negedge clk); @(negedge clk);
    rst = 1; @(negedge clk); rst = 0;
    c0_write = 0; c0_read = 1; c1_read = 1; #1;
    n_cmp++; if ({c0_ready, c1_ready} !== 2'b10) begin
      n_err++; $display("FAIL ril_arb got c0/c1=%b%b want 10", c0_ready, c1_ready); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL ril_err got %b want 0", err); end
    @(negedge clk); c0_read = 0; #1;
    n_cmp++; if (c1_ready !== 1'b1) begin n_err++; $display("FAIL ril_c1 got %b want 1", c1_ready); end
    @(negedge clk); c1_read = 0;
    do_reset();
  endtask

  task automatic test_random();
    int beats[$];   // client id per expected response beat, in order
    int cmds[$];    // beats still owed per outstanding read command
    int pref, win, n;
    bit p_rd[2], p_wr[2], req[2], ok, hd;
    int p_bc[2];
    logic [DW-1:0] d;
    do_reset();
    pref = 0;
    for (int c = 0; c < 2; c++) begin p_rd[c] = 0; p_wr[c] = 0; p_bc[c] = 1; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < 2; c++)
        if (!p_rd[c] && !p_wr[c] && $urandom_range(2) == 0) begin
          if ($urandom_range(3) == 0) begin p_wr[c] = 1; p_bc[c] = 1; end
          else begin p_rd[c] = 1; p_bc[c] = $urandom_range(3, 1); end
        end
      c0_read = p_rd[0]; c0_write = p_wr[0]; c0_bc = 4'(p_bc[0]); c0_addr = $urandom;
      c1_read = p_rd[1]; c1_write = p_wr[1]; c1_bc = 4'(p_bc[1]); c1_addr = $urandom;
      mem_ready = ($urandom_range(3) != 0);
      mem_rdv = (beats.size() > 0) && ($urandom_range(1) == 1);
      d = $urandom; mem_rdata = d;
      #1;
      for (int c = 0; c < 2; c++) req[c] = p_rd[c] | p_wr[c];
      win = (req[0] && req[1]) ? pref : (req[1] ? 1 : 0);
      ok = mem_ready && (p_wr[win] || (p_rd[win] && cmds.size() < 8));
      n_cmp++; if (c0_ready !== (ok && win == 0) || c1_ready !== (ok && win == 1)) begin
        n_err++; $display("FAIL rnd_ready cyc %0d got c0/c1=%b%b want ok=%0d win=%0d", cyc, c0_ready, c1_ready, ok, win); end
      hd = 0;
      if (mem_rdv) hd = beats[0][0];
      n_cmp++; if (c0_rdv !== (mem_rdv && !hd) || c1_rdv !== (mem_rdv && hd) || (mem_rdv && c0_rdata !== d)) begin
        n_err++; $display("FAIL rnd_rsp cyc %0d got rdv0/1=%b%b want valid=%b client %0d", cyc, c0_rdv, c1_rdv, mem_rdv, hd); end
      if (mem_rdv) begin
        void'(beats.pop_front());
        cmds[0] = cmds[0] - 1;
        if (cmds[0] == 0) void'(cmds.pop_front());
      end
      if (ok) begin
        pref = 1 - win;
        if (p_rd[win]) begin
          cmds.push_back(p_bc[win]);
          for (int b = 0; b < p_bc[win]; b++) beats.push_back(win);
        end
        p_rd[win] = 0; p_wr[win] = 0;
      end
      @(negedge clk);
    end
    c0_read = 0; c0_write = 0; c1_read = 0; c1_write = 0;
    n = beats.size();
    for (int i = 0; i < n; i++) begin
      hd = beats.pop_front() == 1; mem_rdv = 1; #1;
      n_cmp++; if (c0_rdv !== !hd || c1_rdv !== hd) begin
        n_err++; $display("FAIL rnd_drain %0d got rdv0/1=%b%b want client %0d", i, c0_rdv, c1_rdv, hd); end
      @(negedge clk);
    end
    mem_rdv = 0; #1;
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rnd_err got %b want 0", err); end
  endtask

  initial begin
    rst = 1; clr_inputs();
    test_reset();
    test_write_lock();
    test_alternate();
    test_burst_steer();
    test_full();
    test_stall();
    test_err();
    test_reset_in_lock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
